attopu_loader: RTL and testbench



---
 rtl/attopu_loader_pkg.sv | 29 ++
 rtl/attopu_loader_chk.sv | 27 ++
 rtl/attopu_loader.sv | 127 ++++++++++++
 tb/tb_attopu_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/attopu_loader_pkg.sv
// Shared definitions for the attopu program loader: memory depth and FSM states.
// ATTOPU_LOADER_CHECKSUM_EN adds the CHK state (and widens the state encoding).
package attopu_loader_pkg;

  localparam int unsigned MEM_WORDS = 1024;

`ifdef ATTOPU_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_DONE, S_ERR
  } state_e;
`endif

  function automatic logic accepts_bytes(input state_e s);
`ifdef ATTOPU_LOADER_CHECKSUM_EN
    return s inside {S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CHK};
`else
    return s inside {S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO};
`endif
  endfunction

  function automatic logic is_busy(input state_e s);
    return !(s inside {S_IDLE, S_DONE, S_ERR});
  endfunction

endpackage

// File: rtl/attopu_loader_chk.sv
// Checksum accumulator for the attopu loader: modulo-256 sum of accepted bytes.
// Instantiated by attopu_loader only when ATTOPU_LOADER_CHECKSUM_EN is defined.
module attopu_loader_chk
  import attopu_loader_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [7:0] byte_i,
  input  logic [7:0] cmp_i,
  output logic       match_o
);

  logic [7:0] sum_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      sum_q <= '0;
    end else if (add_i) begin
      sum_q <= sum_q + byte_i;
    end
  end

  assign match_o = (sum_q == cmp_i);

endmodule

// File: rtl/attopu_loader.sv
// attopu program loader: byte stream (count, then big-endian words) into memory.
// Optional trailing checksum byte when ATTOPU_LOADER_CHECKSUM_EN is defined.
module attopu_loader
  import attopu_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_data,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef ATTOPU_LOADER_CHECKSUM_EN
  localparam state_e S_TAIL = S_CHK;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, idx_q;
  logic [7:0]  hi_q;
  logic        in_ready_q, mem_we_q, cpu_rst_q, busy_q, done_q, error_q;
  logic [15:0] mem_addr_q, mem_data_q;

  logic        xfer, load_start;
  logic [15:0] idx_inc, cnt_rx;

  assign xfer       = in_valid && in_ready_q;
  assign load_start = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign idx_inc    = idx_q + 16'd1;
  assign cnt_rx     = {cnt_q[15:8], in_data};

`ifdef ATTOPU_LOADER_CHECKSUM_EN
  logic chk_match;

  attopu_loader_chk u_chk (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (load_start),
    .add_i   (xfer && (state_q != S_CHK)),
    .byte_i  (in_data),
    .cmp_i   (in_data),
    .match_o (chk_match)
  );
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (load_start) state_d = S_CNT_HI;
      S_CNT_HI: if (xfer) state_d = S_CNT_LO;
      S_CNT_LO: begin
        if (xfer) begin
          if ({16'd0, cnt_rx} > MAX_WORDS) state_d = S_ERR;
          else if (cnt_rx == 16'd0)        state_d = S_TAIL;
          else                             state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: if (xfer) state_d = S_DAT_LO;
      S_DAT_LO: if (xfer) state_d = S_WRITE;
      S_WRITE:  state_d = (idx_inc == cnt_q) ? S_TAIL : S_DAT_HI;
`ifdef ATTOPU_LOADER_CHECKSUM_EN
      S_CHK:    if (xfer) state_d = chk_match ? S_DONE : S_ERR;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state register itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= accepts_bytes(state_d);
      busy_q     <= is_busy(state_d);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERR);
      cpu_rst_q  <= (state_d != S_DONE);
      mem_we_q   <= (state_d == S_WRITE);

      if (load_start)          idx_q <= '0;
      if (state_q == S_WRITE)  idx_q <= idx_inc;

      if (xfer && state_q == S_CNT_HI) cnt_q[15:8] <= in_data;
      if (xfer && state_q == S_CNT_LO) cnt_q       <= cnt_rx;
      if (xfer && state_q == S_DAT_HI) hi_q        <= in_data;
      if (xfer && state_q == S_DAT_LO) begin
        mem_addr_q <= BASE_ADDR + idx_q;
        mem_data_q <= {hi_q, in_data};
      end
    end
  end

  assign in_ready = in_ready_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign cpu_rst  = cpu_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_attopu_loader.sv
// Self-checking bench for attopu_loader: directed and randomized byte streams
// compared against a stream-level model of the expected writes and final status.
module tb_attopu_loader;

  localparam int unsigned MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_rst, busy, done, error;
  logic [15:0] mem_addr, mem_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] obs_q[$];
  int          wr_ready_viol = 0;

  attopu_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_data (mem_data),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_q.push_back({mem_addr, mem_data});
      if (in_ready !== 1'b0) wr_ready_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] bytes[$], input int unsigned max_idle);
    for (int i = 0; i < bytes.size(); i++) begin
      int unsigned idle;
      int waited;
      idle = $urandom_range(max_idle, 0);
      repeat (idle) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = bytes[i];
      waited   = 0;
      while (in_ready !== 1'b1 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Model: a load of n words writes word i to BASE+i, ends in DONE unless the
  // count exceeds the memory depth or (with checksum) the trailing byte is wrong.
  task automatic do_load(input logic [15:0] n, input logic [15:0] words_in[$],
                         input int unsigned max_idle, input bit bad_sum);
    logic [15:0] words[$];
    logic [7:0]  stream[$];
    logic [7:0]  sum;
    bit          fits, exp_ok;
    fits   = (int'(n) <= int'(MAXW));
    exp_ok = fits;
    if (fits) begin
      for (int i = 0; i < int'(n); i++)
        words.push_back((words_in.size() == int'(n)) ? words_in[i] : 16'($urandom));
    end
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    foreach (words[i]) begin
      logic [15:0] w;
      w = words[i];
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
    end
`ifdef ATTOPU_LOADER_CHECKSUM_EN
    sum = '0;
    foreach (stream[i]) sum = sum + stream[i];
    if (fits) begin
      stream.push_back(bad_sum ? sum + 8'd1 : sum);
      exp_ok = !bad_sum;
    end
`else
    sum = '0;
`endif
    obs_q.delete();
    wr_ready_viol = 0;
    pulse_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_ready", {31'd0, in_ready}, 32'd1);
    send(stream, max_idle);
`ifndef ATTOPU_LOADER_CHECKSUM_EN
    if (fits && n != 16'd0) begin
      chk("last_write_we", {31'd0, mem_we}, 32'd1);
      chk("last_write_addr", {16'd0, mem_addr}, {16'd0, n - 16'd1});
      chk("done_before_edge", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
`endif
    chk("end_done", {31'd0, done}, {31'd0, exp_ok});
    chk("end_error", {31'd0, error}, {31'd0, !exp_ok});
    chk("end_cpu_rst", {31'd0, cpu_rst}, {31'd0, !exp_ok});
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("write_count", obs_q.size(), words.size());
    for (int i = 0; i < words.size() && i < obs_q.size(); i++)
      chk("write_entry", obs_q[i], {16'(i), words[i]});
    chk("ready_in_write", wr_ready_viol, 32'd0);
  endtask

  initial begin
    logic [15:0] none[$];
    logic [15:0] basic[$];
    logic [15:0] one[$];
    logic [7:0]  part[$];
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'h0000);
    chk("rst_mem_data", {16'd0, mem_data}, 32'h0000);
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic load, then with backpressure
    basic.push_back(16'h1234);
    basic.push_back(16'hABCD);
    do_load(16'd2, basic, 0, 1'b0);
    do_load(16'd2, basic, 5, 1'b0);

    // Empty image: DONE right after the second count byte (no checksum)
    do_load(16'd0, none, 0, 1'b0);

    // Randomized loads with random gaps
    for (int k = 0; k < 6; k++)
      do_load(16'($urandom_range(8, 1)), none, 5, 1'b0);

    // Oversize count, extra bytes ignored, then recovery
    do_load(16'h0401, none, 0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("err_ready_low", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("err_no_writes", obs_q.size(), 32'd0);
    chk("err_sticky", {31'd0, error}, 32'd1);
    do_load(16'd3, none, 2, 1'b0);

    // Largest accepted count
    do_load(16'(MAXW), none, 0, 1'b0);

    // Reset after the first WRITE of a 3-word image
    obs_q.delete();
    pulse_start();
    part.push_back(8'h00); part.push_back(8'h03);
    part.push_back(8'hBE); part.push_back(8'hEF);
    send(part, 0);
    chk("midrst_we_pre", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    chk("midrst_writes", obs_q.size(), 32'd1);
    if (obs_q.size() > 0) chk("midrst_entry", obs_q[0], 32'h0000BEEF);
    do_load(16'd3, none, 3, 1'b0);

`ifdef ATTOPU_LOADER_CHECKSUM_EN
    // 00 01 00 05 with trailing 06 (good) and 07 (bad)
    one.push_back(16'h0005);
    do_load(16'd1, one, 0, 1'b0);
    do_load(16'd1, one, 0, 1'b1);
    do_load(16'd4, none, 4, 1'b1);
`else
    one.push_back(16'h0005);
    do_load(16'd1, one, 1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
